// File: rtl/axi_lite_write_master_if.sv
// Bundles the sequencer request handshake and the AXI4-Lite AW/W/B channels.
// Latency: none, wiring only.
// Backpressure: carried by lite_ready and by m_axi_awready/wready/bready.
interface axi_lite_write_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Sequencer request side
    logic              lite_valid;
    logic [ADDR_W-1:0] lite_awaddr;
    logic [DATA_W-1:0] lite_wdata;
    logic              lite_ready;
    logic              lite_end;
    logic              lite_err;

    // AXI4-Lite write channels
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [2:0]        m_axi_awprot;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;

    // Engine view
    modport master (
        input  lite_valid, lite_awaddr, lite_wdata,
        output lite_ready, lite_end, lite_err,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    // Sequencer plus register-slave view
    modport slave (
        output lite_valid, lite_awaddr, lite_wdata,
        input  lite_ready, lite_end, lite_err,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axi_lite_write_master.sv
// AXI4-Lite single-beat write master for the MM2S lite register sequencer; optional retry via LITE_RETRY_EN.
// Latency: request to lite_end minimum 3 cycles, back-to-back throughput one write per 3 cycles.
// Backpressure: lite_ready low while busy; AW/W valids held until their handshakes, bready only in RESP.
module axi_lite_write_master #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_lite_write_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_RESP      = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    // The address/data holding registers double as the AXI address/data outputs.
    logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0] r_wdata,  w_wdata_nxt;
    logic              r_awvalid, w_awvalid_nxt;
    logic              r_wvalid,  w_wvalid_nxt;
    logic              r_bready,  w_bready_nxt;
    logic              r_end,     w_end_nxt;
    logic              r_err,     w_err_nxt;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;
    logic w_b_err;

`ifdef LITE_RETRY_EN
    localparam int CNT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);
    logic [CNT_W-1:0] r_retry_cnt, w_retry_cnt_nxt;
`else
    logic w_unused_max_retry;
    assign w_unused_max_retry = (MAX_RETRY > 0);
`endif

    // A channel counts as done once its valid has dropped, or if it handshakes this cycle.
    assign w_aw_hs   = r_awvalid & bus.m_axi_awready;
    assign w_w_hs    = r_wvalid  & bus.m_axi_wready;
    assign w_aw_done = ~r_awvalid | w_aw_hs;
    assign w_w_done  = ~r_wvalid  | w_w_hs;
    assign w_b_hs    = r_bready  & bus.m_axi_bvalid;
    assign w_b_err   = (bus.m_axi_bresp != 2'b00);

    // Next-state and next-output decode; every registered output is decided here.
    always_comb begin
        w_state_nxt   = r_state;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_end_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
`ifdef LITE_RETRY_EN
        w_retry_cnt_nxt = r_retry_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.lite_valid) begin
                    w_awaddr_nxt  = bus.lite_awaddr;
                    w_wdata_nxt   = bus.lite_wdata;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_state_nxt   = S_ADDR_DATA;
`ifdef LITE_RETRY_EN
                    w_retry_cnt_nxt = '0;
`endif
                end
            end
            S_ADDR_DATA: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt = 1'b0;
`ifdef LITE_RETRY_EN
                    if (w_b_err && (r_retry_cnt < MAX_CNT)) begin
                        // Reissue the same beat from the holding registers.
                        w_retry_cnt_nxt = r_retry_cnt + 1'b1;
                        w_awvalid_nxt   = 1'b1;
                        w_wvalid_nxt    = 1'b1;
                        w_state_nxt     = S_ADDR_DATA;
                    end else begin
                        w_end_nxt   = 1'b1;
                        w_err_nxt   = w_b_err;
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_end_nxt   = 1'b1;
                    w_err_nxt   = w_b_err;
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_end     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_end     <= w_end_nxt;
            r_err     <= w_err_nxt;
        end
    end

`ifdef LITE_RETRY_EN
    // Retry counter, cleared on each newly accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retry_cnt <= '0;
        end else begin
            r_retry_cnt <= w_retry_cnt_nxt;
        end
    end
`endif

    assign bus.lite_ready    = (r_state == S_IDLE);
    assign bus.lite_end      = r_end;
    assign bus.lite_err      = r_err;
    assign bus.m_axi_awaddr  = r_awaddr;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wstrb   = 4'hF;
    assign bus.m_axi_wvalid  = r_wvalid;
    assign bus.m_axi_bready  = r_bready;
endmodule

// File: tb/tb_axi_lite_write_master.sv
// Directed bench for axi_lite_write_master: table of single writes plus reset and back-to-back sequences.
// Latency expectations per vector are hand-computed from channel ready/valid delays.
// Backpressure is exercised by delaying awready, wready and bvalid per vector.
module tb_axi_lite_write_master;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axi_lite_write_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    axi_lite_write_master #(.ADDR_W(10), .DATA_W(32), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          aw_dly;    // cycles awvalid waits before awready
        int          w_dly;     // cycles wvalid waits before wready
        int          b_dly;     // cycles bready waits before bvalid
        bit          b_early;   // bvalid already high before RESP
        int          n_err;     // number of responses that carry bresp before OKAY
        logic [1:0]  bresp;
        int          ign_cyc;   // cycle in which a stray lite_valid is pulsed (0 = none)
        int          exp_lat;   // cycle of lite_end, request accepted in cycle 0
        bit          exp_err;
        int          exp_beats;
        int          exp_awv;   // cycles with awvalid high
        int          exp_wv;    // cycles with wvalid high
        int          exp_brdy;  // cycles with bready high
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] a, input logic [31:0] d,
                                input int awd, input int wd, input int bd, input bit early,
                                input int nerr, input logic [1:0] br, input int ign,
                                input int lat, input bit err, input int beats,
                                input int awv, input int wv, input int brdy);
        vec_t v;
        v.addr = a; v.data = d; v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd;
        v.b_early = early; v.n_err = nerr; v.bresp = br; v.ign_cyc = ign;
        v.exp_lat = lat; v.exp_err = err; v.exp_beats = beats;
        v.exp_awv = awv; v.exp_wv = wv; v.exp_brdy = brdy;
        return v;
    endfunction

    // Entered and left on a falling edge; the request is presented in the entry cycle (cycle 0).
    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0, end_cyc = -1, end_cnt = 0;
        int aw_hs = 0, w_hs = 0, b_hs = 0, awv = 0, wv = 0, brdy = 0;
        int aw_wait = 0, w_wait = 0, b_wait = 0, bad_beat = 0;
        logic err_at_end = 1'b0;
        check($sformatf("v%0d_ready", idx), bus.lite_ready, 1'b1);
        bus.lite_valid    = 1'b1;
        bus.lite_awaddr   = v.addr;
        bus.lite_wdata    = v.data;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = v.b_early;
        bus.m_axi_bresp   = (v.n_err > 0) ? v.bresp : 2'b00;
        while (end_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.lite_valid = (cyc == v.ign_cyc);
            if (cyc == v.ign_cyc) begin
                bus.lite_awaddr = ~v.addr;
                bus.lite_wdata  = ~v.data;
            end
            if (bus.lite_end) begin
                end_cnt++;
                end_cyc    = cyc;
                err_at_end = bus.lite_err;
            end
            bus.m_axi_awready = 1'b0;
            if (bus.m_axi_awvalid) begin
                awv++;
                if (aw_wait >= v.aw_dly) begin
                    bus.m_axi_awready = 1'b1;
                    aw_hs++;
                    aw_wait = 0;
                    if (bus.m_axi_awaddr !== v.addr || bus.m_axi_awprot !== 3'b000) bad_beat++;
                end else begin
                    aw_wait++;
                end
            end
            bus.m_axi_wready = 1'b0;
            if (bus.m_axi_wvalid) begin
                wv++;
                if (w_wait >= v.w_dly) begin
                    bus.m_axi_wready = 1'b1;
                    w_hs++;
                    w_wait = 0;
                    if (bus.m_axi_wdata !== v.data || bus.m_axi_wstrb !== 4'hF) bad_beat++;
                end else begin
                    w_wait++;
                end
            end
            if (bus.m_axi_bready) begin
                brdy++;
                if (b_wait >= v.b_dly) begin
                    bus.m_axi_bvalid = 1'b1;
                    bus.m_axi_bresp  = (b_hs < v.n_err) ? v.bresp : 2'b00;
                    b_hs++;
                    b_wait = 0;
                end else begin
                    bus.m_axi_bvalid = 1'b0;
                    b_wait++;
                end
            end else begin
                bus.m_axi_bvalid = v.b_early && (b_hs == 0);
                bus.m_axi_bresp  = (v.n_err > 0) ? v.bresp : 2'b00;
            end
        end
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_bresp  = 2'b00;
        check($sformatf("v%0d_latency", idx), end_cyc, v.exp_lat);
        check($sformatf("v%0d_err", idx), err_at_end, v.exp_err);
        check($sformatf("v%0d_end_cnt", idx), end_cnt, 1);
        check($sformatf("v%0d_aw_beats", idx), aw_hs, v.exp_beats);
        check($sformatf("v%0d_w_beats", idx), w_hs, v.exp_beats);
        check($sformatf("v%0d_b_beats", idx), b_hs, v.exp_beats);
        check($sformatf("v%0d_awvalid_cycles", idx), awv, v.exp_awv);
        check($sformatf("v%0d_wvalid_cycles", idx), wv, v.exp_wv);
        check($sformatf("v%0d_bready_cycles", idx), brdy, v.exp_brdy);
        check($sformatf("v%0d_beat_content", idx), bad_beat, 0);
    endtask

    initial begin
        //            addr    data          awd wd bd early nerr bresp ign lat err beats awv wv brdy
        vecs[0]  = mk(10'h018, 32'h1000_0000, 0, 0, 0, 1'b0, 0, 2'b00, 0, 3, 1'b0, 1, 1, 1, 1);
        vecs[1]  = mk(10'h020, 32'hCAFE_0001, 4, 1, 0, 1'b0, 0, 2'b00, 0, 7, 1'b0, 1, 5, 2, 1);
        vecs[2]  = mk(10'h000, 32'h1111_1111, 0, 0, 0, 1'b0, 0, 2'b00, 0, 3, 1'b0, 1, 1, 1, 1);
        vecs[3]  = mk(10'h004, 32'h2222_2222, 0, 0, 0, 1'b0, 0, 2'b00, 0, 3, 1'b0, 1, 1, 1, 1);
        vecs[4]  = mk(10'h018, 32'h3333_3333, 0, 0, 0, 1'b0, 0, 2'b00, 0, 3, 1'b0, 1, 1, 1, 1);
        vecs[5]  = mk(10'h01C, 32'h4444_4444, 0, 0, 0, 1'b0, 0, 2'b00, 0, 3, 1'b0, 1, 1, 1, 1);
        vecs[6]  = mk(10'h028, 32'h5555_5555, 0, 0, 0, 1'b0, 0, 2'b00, 0, 3, 1'b0, 1, 1, 1, 1);
`ifdef LITE_RETRY_EN
        vecs[7]  = mk(10'h030, 32'h0BAD_0BAD, 0, 0, 0, 1'b0, 99, 2'b10, 0, 9, 1'b1, 4, 4, 4, 4);
        vecs[8]  = mk(10'h034, 32'h0000_0042, 0, 0, 0, 1'b0, 1, 2'b10, 0, 5, 1'b0, 2, 2, 2, 2);
        vecs[9]  = mk(10'h038, 32'hDEC0_DEC0, 0, 2, 0, 1'b0, 99, 2'b11, 0, 17, 1'b1, 4, 4, 12, 4);
`else
        vecs[7]  = mk(10'h030, 32'h0BAD_0BAD, 0, 0, 0, 1'b0, 99, 2'b10, 0, 3, 1'b1, 1, 1, 1, 1);
        vecs[8]  = mk(10'h034, 32'h0000_0042, 0, 0, 0, 1'b0, 1, 2'b10, 0, 3, 1'b1, 1, 1, 1, 1);
        vecs[9]  = mk(10'h038, 32'hDEC0_DEC0, 0, 2, 0, 1'b0, 99, 2'b11, 0, 5, 1'b1, 1, 1, 3, 1);
`endif
        vecs[10] = mk(10'h03C, 32'h1234_5678, 0, 0, 2, 1'b0, 0, 2'b00, 3, 5, 1'b0, 1, 1, 1, 3);
        vecs[11] = mk(10'h3FC, 32'hFFFF_FFFF, 3, 0, 0, 1'b1, 0, 2'b00, 0, 6, 1'b0, 1, 4, 1, 1);
        vecs[12] = mk(10'h200, 32'h8000_0001, 2, 2, 1, 1'b0, 0, 2'b00, 0, 6, 1'b0, 1, 3, 3, 2);

        rst               = 1'b0;
        bus.lite_valid    = 1'b0;
        bus.lite_awaddr   = '0;
        bus.lite_wdata    = '0;
        bus.m_axi_awready = 1'b0;
        bus.m_axi_wready  = 1'b0;
        bus.m_axi_bvalid  = 1'b0;
        bus.m_axi_bresp   = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready",   bus.lite_ready,    1'b1);
        check("reset_awvalid", bus.m_axi_awvalid, 1'b0);
        check("reset_wvalid",  bus.m_axi_wvalid,  1'b0);
        check("reset_bready",  bus.m_axi_bready,  1'b0);
        check("reset_end",     bus.lite_end,      1'b0);
        check("reset_err",     bus.lite_err,      1'b0);
        check("reset_awaddr",  bus.m_axi_awaddr,  10'h000);
        check("reset_wdata",   bus.m_axi_wdata,   32'h0);
        check("reset_awprot",  bus.m_axi_awprot,  3'b000);
        check("reset_wstrb",   bus.m_axi_wstrb,   4'hF);
        rst = 1'b1;
        @(negedge clk);

        // Vectors 2..6 run back-to-back: each request is presented in the previous lite_end cycle.
        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i]);
        end

        // lite_end must drop the cycle after the last pulse.
        @(negedge clk);
        check("end_one_cycle", bus.lite_end, 1'b0);

        // Reset while AW/W are pending: outputs clear immediately, then a normal write completes.
        bus.lite_valid  = 1'b1;
        bus.lite_awaddr = 10'h044;
        bus.lite_wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lite_valid = 1'b0;
        check("rst_mid_pre_awvalid", bus.m_axi_awvalid, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_awvalid", bus.m_axi_awvalid, 1'b0);
        check("rst_mid_wvalid",  bus.m_axi_wvalid,  1'b0);
        check("rst_mid_bready",  bus.m_axi_bready,  1'b0);
        check("rst_mid_awaddr",  bus.m_axi_awaddr,  10'h000);
        check("rst_mid_wdata",   bus.m_axi_wdata,   32'h0);
        check("rst_mid_end",     bus.lite_end,      1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_idle_ready", bus.lite_ready, 1'b1);
        check("rst_mid_idle_awvalid", bus.m_axi_awvalid, 1'b0);
        run_vec(100, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
